// File: rtl/bf_norm_div.sv
`default_nettype none
// ============================================================================
// Module      : bf_norm_div
// Description : Accumulate-and-normalise stage of the bilateral filter.
//               Sums weight x intensity products and weights over one
//               window, then divides with an 8-cycle restoring divider to
//               produce a round-half-up 8-bit filtered pixel.
// Revision    : 1.0 - initial release
// ============================================================================
module bf_norm_div #(
  parameter int NTAPS = 121,
  parameter int PW    = 15,
  parameter int WW    = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_prod,
  input  logic [WW-1:0] in_w,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [7:0]    out_pix,
  output logic          out_zero_w,
  output logic          sync_err
);

  // Counter and accumulator widths; sums cannot overflow for NTAPS taps.
  localparam int CW  = $clog2(NTAPS);
  localparam int SPW = PW + CW;
  localparam int SWW = WW + CW;
  localparam int RW  = SPW + 1;

  localparam logic [CW-1:0] LAST_CNT = CW'(NTAPS - 1);

  localparam logic [1:0] S_ACC = 2'd0;
  localparam logic [1:0] S_DIV = 2'd1;
  localparam logic [1:0] S_OUT = 2'd2;

  logic [1:0]     state;
  logic [1:0]     state_nxt;
  logic [CW-1:0]  count;
  logic [SPW-1:0] sum_p;
  logic [SWW-1:0] sum_w;
  logic [RW-1:0]  rem;
  logic [SWW-1:0] divisor;
  logic [7:0]     quot;
  logic [2:0]     bit_idx;
  logic [7:0]     pix;
  logic           zero_w;
  logic           err;

  logic           tap_xfer;
  logic           at_last_cnt;
  logic           win_end;
  logic [SPW-1:0] sum_p_nxt;
  logic [SWW-1:0] sum_w_nxt;
  logic [RW-1:0]  dividend;
  logic [RW-1:0]  shifted_w;
  logic           q_bit;

  assign tap_xfer    = in_valid & in_ready;
  assign at_last_cnt = (count == LAST_CNT);
  assign win_end     = tap_xfer & (in_last | at_last_cnt);

  // Running sums including the tap being transferred this cycle.
  assign sum_p_nxt = sum_p + SPW'(in_prod);
  assign sum_w_nxt = sum_w + SWW'(in_w);

  // Adding half the divisor turns the truncating divide into round-half-up.
  assign dividend = RW'(sum_p_nxt) + RW'(sum_w_nxt[SWW-1:1]);

  // A zero divisor must never produce a quotient bit.
  assign shifted_w = RW'(divisor) << bit_idx;
  assign q_bit     = (divisor != '0) && (rem >= shifted_w);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_ACC;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: accumulate, divide for 8 cycles, then hold result.
  always_comb begin
    state_nxt = state;
    case (state)
      S_ACC:   if (win_end) state_nxt = S_DIV;
      S_DIV:   if (bit_idx == 3'd0) state_nxt = S_OUT;
      S_OUT:   if (out_ready) state_nxt = S_ACC;
      default: state_nxt = S_ACC;
    endcase
  end

  // Handshake outputs decoded directly from the state.
  always_comb begin
    in_ready  = (state == S_ACC);
    out_valid = (state == S_OUT);
  end

  // Datapath: accumulators, restoring divider, result and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= '0;
      sum_p   <= '0;
      sum_w   <= '0;
      rem     <= '0;
      divisor <= '0;
      quot    <= '0;
      bit_idx <= '0;
      pix     <= '0;
      zero_w  <= 1'b0;
      err     <= 1'b0;
    end else begin
      case (state)
        S_ACC: begin
          if (tap_xfer) begin
            count <= count + 1'b1;
            sum_p <= sum_p_nxt;
            sum_w <= sum_w_nxt;
          end
          if (win_end) begin
            rem     <= dividend;
            divisor <= sum_w_nxt;
            bit_idx <= 3'd7;
            quot    <= '0;
            // Window closed by only one of the two criteria: framing is off.
            if (in_last != at_last_cnt) err <= 1'b1;
          end
        end
        S_DIV: begin
          if (q_bit) rem <= rem - shifted_w;
          quot    <= {quot[6:0], q_bit};
          bit_idx <= bit_idx - 3'd1;
          if (bit_idx == 3'd0) begin
            pix    <= {quot[6:0], q_bit};
            zero_w <= (divisor == '0);
          end
        end
        S_OUT: begin
          if (out_ready) begin
            count <= '0;
            sum_p <= '0;
            sum_w <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_pix    = pix;
  assign out_zero_w = zero_w;
  assign sync_err   = err;

endmodule
`default_nettype wire

// File: tb/tb_bf_norm_div.sv
`default_nettype none
// ============================================================================
// Module      : tb_bf_norm_div
// Description : Self-checking bench for bf_norm_div. Directed windows from
//               the test plan plus randomized windows, checked against an
//               arithmetic reference of the rounded weighted mean.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bf_norm_div;

  localparam int NTAPS = 121;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [14:0] in_prod;
  logic [6:0]  in_w;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_pix;
  logic        out_zero_w;
  logic        sync_err;

  bf_norm_div #(.NTAPS(NTAPS), .PW(15), .WW(7)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_prod    (in_prod),
    .in_w       (in_w),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pix    (out_pix),
    .out_zero_w (out_zero_w),
    .sync_err   (sync_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit exp_se = 1'b0;
  int tw [0:NTAPS-1];
  int tp [0:NTAPS-1];
  int exp_pix;
  int exp_zw;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Present taps 0..n-1 and compute the reference result for the window.
  task automatic feed(input int n, input int last_idx, input bit gaps);
    int sp;
    int sw;
    sp = 0;
    sw = 0;
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        in_w     = 7'($urandom);
        in_prod  = 15'($urandom);
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_w     = 7'(tw[i]);
      in_prod  = 15'(tp[i]);
      in_last  = (i == last_idx);
      if (i == 0) check("acc_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      sp += tp[i];
      sw += tw[i];
    end
    if (!((n - 1) == NTAPS - 1 && last_idx == n - 1)) exp_se = 1'b1;
    if (sw == 0) begin
      exp_pix = 0;
      exp_zw  = 1;
    end else begin
      exp_pix = (sp + sw / 2) / sw;
      exp_zw  = 0;
    end
    // Inputs stay busy with junk while the block is dividing.
    in_valid = 1'b1;
    in_last  = 1'b1;
    in_w     = 7'($urandom);
    in_prod  = 15'($urandom);
  endtask

  task automatic run_window(input string tag, input int n, input int last_idx,
                            input int hold, input bit gaps);
    int lat;
    feed(n, last_idx, gaps);
    check({tag, "_gap_ready"}, 32'(in_ready), 32'd0);
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = c;
        break;
      end
    end
    check({tag, "_latency"}, 32'(lat), 32'd8);
    check({tag, "_pix"}, 32'(out_pix), 32'(exp_pix));
    check({tag, "_zero_w"}, 32'(out_zero_w), 32'(exp_zw));
    check({tag, "_sync_err"}, 32'(sync_err), 32'(exp_se));
    out_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_hold_ready"}, 32'(in_ready), 32'd0);
      check({tag, "_hold_pix"}, 32'(out_pix), 32'(exp_pix));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    check({tag, "_done_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_done_ready"}, 32'(in_ready), 32'd1);
  endtask

  task automatic fill(input int w, input int p);
    for (int i = 0; i < NTAPS; i++) begin
      tw[i] = w;
      tp[i] = p;
    end
  endtask

  initial begin
    int n;
    int li;
    int r;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_prod   = '0;
    in_w      = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_pix", 32'(out_pix), 32'd0);
    check("rst_zero_w", 32'(out_zero_w), 32'd0);
    check("rst_sync_err", 32'(sync_err), 32'd0);
    rst = 1'b0;

    fill(1, 100);
    run_window("flat100", NTAPS, NTAPS - 1, 0, 1'b0);

    fill(0, 0);
    tw[0] = 2; tp[0] = 20; tw[1] = 1; tp[1] = 12;
    run_window("round_up", NTAPS, NTAPS - 1, 0, 1'b0);
    tp[1] = 11;
    run_window("round_dn", NTAPS, NTAPS - 1, 0, 1'b0);

    fill(127, 32385);
    run_window("max", NTAPS, NTAPS - 1, 5, 1'b0);

    fill(0, 0);
    run_window("zero_w", NTAPS, NTAPS - 1, 0, 1'b0);

    fill(1, 40);
    run_window("short", 51, 50, 0, 1'b0);

    for (int i = 0; i < NTAPS; i++) begin
      tw[i] = $urandom_range(0, 127);
      tp[i] = tw[i] * $urandom_range(0, 255);
    end
    run_window("no_last", NTAPS, -1, 0, 1'b0);

    // Abort a window on its 4th divide cycle.
    fill(127, 32385);
    feed(NTAPS, NTAPS - 1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    exp_se   = 1'b0;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_sync_err", 32'(sync_err), 32'd0);
    fill(3, 3 * 77);
    run_window("after_abort", NTAPS, NTAPS - 1, 2, 1'b0);

    for (int k = 0; k < 20; k++) begin
      r = $urandom_range(0, 3);
      if (r == 0) begin
        n = NTAPS; li = NTAPS - 1;
      end else if (r == 1) begin
        n = NTAPS; li = -1;
      end else begin
        n = $urandom_range(1, NTAPS - 1); li = n - 1;
      end
      for (int i = 0; i < NTAPS; i++) begin
        tw[i] = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(0, 127);
        tp[i] = tw[i] * $urandom_range(0, 255);
      end
      run_window("rand", n, li, $urandom_range(0, 3), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
